layer_link: RTL
===============

LAYER_LINK -- requirements
Module: layer_link

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles spent in any wait state before abort.
REQ-002 clk  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 up_valid  input  1  upstream layer message valid.
REQ-005 up_data  input  63  upstream packed 7x9 forward vector, lane k = bits [7k+6:7k].
REQ-006 up_ack  output  1  one-cycle acknowledge to upstream.
REQ-007 up_backprop  output  1  one-cycle backprop start pulse to upstream.
REQ-008 up_vec  output  63  delta vector driven toward upstream packed input.
REQ-009 up_drive_en  output  1  up_vec valid; system muxes up_vec onto upstream input only while high.
REQ-010 dn_mult  output  1  one-cycle forward start pulse to downstream.
REQ-011 dn_vec  output  63  forward vector to downstream packed input.
REQ-012 dn_valid  input  1  downstream message valid (forward result, later delta).
REQ-013 dn_data  input  63  downstream packed output.
REQ-014 dn_ack  output  1  one-cycle acknowledge to downstream; asserted for delta message only; system ORs it with other ack sources.
REQ-015 err  output  1  sticky timeout flag.
REQ-016 xfer_count  output  8  completed forward+backward round trips, wraps 255->0.
REQ-017 state_dbg  output  4  current FSM state encoding.

Function
REQ-018 States, encodings 0-9: IDLE, F_ACK, F_DROP, F_MULT, F_RES_HI, F_RES_LO, B_WAIT, B_ACK, B_DROP, B_SEND.
REQ-019 IDLE: on up_valid=1 capture up_data into dn_vec, up_ack<=1, go F_ACK.
REQ-020 F_ACK: up_ack<=0, go F_DROP (ack is exactly one cycle).
REQ-021 F_DROP: wait up_valid=0, then dn_mult<=1, go F_MULT; up_data not re-captured.
REQ-022 F_MULT: dn_mult<=0, go F_RES_HI; dn_vec held constant from capture until next IDLE capture.
REQ-023 F_RES_HI: wait dn_valid=1 (forward result, not acked here), go F_RES_LO.
REQ-024 F_RES_LO: wait dn_valid=0 (result consumed by next stage), go B_WAIT.
REQ-025 B_WAIT: on dn_valid=1 capture dn_data into up_vec, dn_ack<=1, go B_ACK.
REQ-026 B_ACK: dn_ack<=0, go B_DROP.
REQ-027 B_DROP: wait dn_valid=0, then up_drive_en<=1, go B_SEND.
REQ-028 B_SEND: up_backprop<=1 for one cycle with up_drive_en=1 and up_vec stable; next cycle up_backprop<=0, up_drive_en<=0, xfer_count+1, go IDLE.
REQ-029 Inputs not named as the waited-for condition of the current state are ignored.
REQ-030 Wait counter: cleared on every state change; increments each cycle in F_DROP, F_RES_HI, F_RES_LO, B_WAIT, B_DROP; reaching TIMEOUT sets err=1, clears all pulse outputs and up_drive_en, goes IDLE; xfer_count unchanged.
REQ-031 err cleared only by reset; block keeps operating with err=1.
REQ-032 Vector data passes bit-exact; no arithmetic on lanes.

Reset
REQ-033 reset=1 at any edge, including mid-transfer: next cycle state IDLE, all outputs 0 (up_vec, dn_vec, xfer_count, err included), wait counter 0.
REQ-034 reset dominates all other inputs in the same cycle.

Verification
REQ-035 up_valid=1, up_data=63'h1 held until ack -> up_ack high exactly one cycle, dn_vec=63'h1, dn_mult one-cycle pulse after up_valid falls.
REQ-036 Full round trip: dn_valid pulse (forward), then dn_valid with dn_data lanes all 7'h7F -> no dn_ack on first, one-cycle dn_ack on second, up_vec=all 7'h7F, up_backprop one cycle with up_drive_en=1, xfer_count=1.
REQ-037 dn_valid never rises after dn_mult, TIMEOUT=255 -> err=1 after 255 cycles in F_RES_HI, state_dbg=0.
REQ-038 256 round trips -> xfer_count wraps to 0.
REQ-039 reset asserted in B_DROP -> next cycle all outputs 0, state_dbg=0; fresh transfer then completes normally.
REQ-040 up_valid toggled during F_RES_HI..B_SEND -> no up_ack, dn_vec unchanged.

Source files
------------

// File: rtl/layer_link_if.sv
// Handshake and vector bus between layer_link, its upstream layer and its downstream layer.
interface layer_link_if;
  logic        up_valid;
  logic [62:0] up_data;
  logic        up_ack;
  logic        up_backprop;
  logic [62:0] up_vec;
  logic        up_drive_en;
  logic        dn_mult;
  logic [62:0] dn_vec;
  logic        dn_valid;
  logic [62:0] dn_data;
  logic        dn_ack;

  // System side: presents upstream/downstream messages, consumes link outputs.
  modport master (
    output up_valid, up_data, dn_valid, dn_data,
    input  up_ack, up_backprop, up_vec, up_drive_en, dn_mult, dn_vec, dn_ack
  );

  // Link side: the layer_link block itself.
  modport slave (
    input  up_valid, up_data, dn_valid, dn_data,
    output up_ack, up_backprop, up_vec, up_drive_en, dn_mult, dn_vec, dn_ack
  );
endinterface

// File: rtl/layer_link.sv
// Forward/backward message link between two network layers: forwards the
// upstream vector downstream, waits for the forward result and the delta,
// then drives the delta back upstream with a backprop pulse.
module layer_link #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic         clk,
  input  logic         reset,
  layer_link_if.slave  lnk,
  output logic         err,
  output logic [7:0]   xfer_count,
  output logic [3:0]   state_dbg
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_F_ACK    = 4'd1;
  localparam logic [3:0] S_F_DROP   = 4'd2;
  localparam logic [3:0] S_F_MULT   = 4'd3;
  localparam logic [3:0] S_F_RES_HI = 4'd4;
  localparam logic [3:0] S_F_RES_LO = 4'd5;
  localparam logic [3:0] S_B_WAIT   = 4'd6;
  localparam logic [3:0] S_B_ACK    = 4'd7;
  localparam logic [3:0] S_B_DROP   = 4'd8;
  localparam logic [3:0] S_B_SEND   = 4'd9;

  localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  // Last count value before abort: TIMEOUT cycles are spent in the wait state.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          up_ack_q, up_ack_d;
  logic          up_backprop_q, up_backprop_d;
  logic [62:0]   up_vec_q, up_vec_d;
  logic          up_drive_en_q, up_drive_en_d;
  logic          dn_mult_q, dn_mult_d;
  logic [62:0]   dn_vec_q, dn_vec_d;
  logic          dn_ack_q, dn_ack_d;
  logic          err_q, err_d;
  logic [7:0]    xfer_count_q, xfer_count_d;
  logic          waiting;

  // Next-state, output-register and wait-counter logic.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    up_ack_d      = up_ack_q;
    up_backprop_d = up_backprop_q;
    up_vec_d      = up_vec_q;
    up_drive_en_d = up_drive_en_q;
    dn_mult_d     = dn_mult_q;
    dn_vec_d      = dn_vec_q;
    dn_ack_d      = dn_ack_q;
    err_d         = err_q;
    xfer_count_d  = xfer_count_q;
    waiting       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (lnk.up_valid) begin
          dn_vec_d = lnk.up_data;
          up_ack_d = 1'b1;
          state_d  = S_F_ACK;
        end
      end
      S_F_ACK: begin
        up_ack_d = 1'b0;
        state_d  = S_F_DROP;
      end
      S_F_DROP: begin
        waiting = 1'b1;
        if (!lnk.up_valid) begin
          dn_mult_d = 1'b1;
          state_d   = S_F_MULT;
        end
      end
      S_F_MULT: begin
        dn_mult_d = 1'b0;
        state_d   = S_F_RES_HI;
      end
      S_F_RES_HI: begin
        waiting = 1'b1;
        if (lnk.dn_valid) state_d = S_F_RES_LO;
      end
      S_F_RES_LO: begin
        waiting = 1'b1;
        if (!lnk.dn_valid) state_d = S_B_WAIT;
      end
      S_B_WAIT: begin
        waiting = 1'b1;
        if (lnk.dn_valid) begin
          up_vec_d = lnk.dn_data;
          dn_ack_d = 1'b1;
          state_d  = S_B_ACK;
        end
      end
      S_B_ACK: begin
        dn_ack_d = 1'b0;
        state_d  = S_B_DROP;
      end
      S_B_DROP: begin
        waiting = 1'b1;
        if (!lnk.dn_valid) begin
          up_drive_en_d = 1'b1;
          up_backprop_d = 1'b1;
          state_d       = S_B_SEND;
        end
      end
      S_B_SEND: begin
        up_backprop_d = 1'b0;
        up_drive_en_d = 1'b0;
        xfer_count_d  = xfer_count_q + 8'd1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Timeout is evaluated only when the waited-for condition did not arrive,
    // so a condition met on the final allowed cycle still wins.
    if (waiting && (state_d == state_q)) begin
      if (cnt_q == CNT_LAST) begin
        err_d         = 1'b1;
        up_ack_d      = 1'b0;
        up_backprop_d = 1'b0;
        up_drive_en_d = 1'b0;
        dn_mult_d     = 1'b0;
        dn_ack_d      = 1'b0;
        state_d       = S_IDLE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
    if (state_d != state_q) cnt_d = '0;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      up_ack_q      <= 1'b0;
      up_backprop_q <= 1'b0;
      up_vec_q      <= '0;
      up_drive_en_q <= 1'b0;
      dn_mult_q     <= 1'b0;
      dn_vec_q      <= '0;
      dn_ack_q      <= 1'b0;
      err_q         <= 1'b0;
      xfer_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      up_ack_q      <= up_ack_d;
      up_backprop_q <= up_backprop_d;
      up_vec_q      <= up_vec_d;
      up_drive_en_q <= up_drive_en_d;
      dn_mult_q     <= dn_mult_d;
      dn_vec_q      <= dn_vec_d;
      dn_ack_q      <= dn_ack_d;
      err_q         <= err_d;
      xfer_count_q  <= xfer_count_d;
    end
  end

  assign lnk.up_ack      = up_ack_q;
  assign lnk.up_backprop = up_backprop_q;
  assign lnk.up_vec      = up_vec_q;
  assign lnk.up_drive_en = up_drive_en_q;
  assign lnk.dn_mult     = dn_mult_q;
  assign lnk.dn_vec      = dn_vec_q;
  assign lnk.dn_ack      = dn_ack_q;
  assign err             = err_q;
  assign xfer_count      = xfer_count_q;
  assign state_dbg       = state_q;

endmodule
